mod_dp: RTL and testbench

Datapath for the unsigned modulo unit. It computes A mod B by repeated subtraction. The mod control unit drives this block through loadA/doSub, and this block returns the loop-exit flag x. It holds the operand registers, the subtractor, the comparator, a quotient counter and the result/done status consumed by downstream logic.

---
 rtl/mod_dp.sv | 60 ++++++
 tb/tb_mod_dp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mod_dp.sv
// Datapath for the unsigned modulo unit: operand registers, guarded subtractor,
// comparator, quotient counter and done/div-zero status.
module mod_dp #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             loadA,
    input  logic             doSub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             x,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] quotient,
    output logic             done,
    output logic             div_zero
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_quot;
    logic             r_done;
    logic             r_dz;

    logic             w_x;
    logic [WIDTH-1:0] w_diff;

    // Terminal condition also covers B==0 so a zero divisor never loops.
    assign w_x    = (r_a < r_b) || (r_b == '0);
    assign w_diff = r_a - r_b;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_quot <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else if (loadA) begin
            r_a    <= a_in;
            r_b    <= b_in;
            r_quot <= '0;
            r_done <= 1'b0;
            r_dz   <= (b_in == '0);
        end else if (doSub && !w_x) begin
            r_a    <= w_diff;
            r_quot <= r_quot + 1'b1;
            r_done <= 1'b0;
        end else if (doSub) begin
            r_done <= 1'b1;
        end
    end

    assign x         = w_x;
    assign remainder = r_a;
    assign quotient  = r_quot;
    assign done      = r_done;
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_mod_dp.sv
// Self-checking bench for mod_dp: table-driven operations through a scoreboard
// plus hand-written reset, step-count, div-zero and restart sequences.
module tb_mod_dp;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic         loadA = 1'b0;
    logic         doSub = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         x;
    logic [W-1:0] remainder;
    logic [W-1:0] quotient;
    logic         done;
    logic         div_zero;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] rem;
        logic [W-1:0] quot;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] rem;
        logic [W-1:0] quot;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    mod_dp #(.WIDTH(W)) dut (
        .CLK(CLK), .reset(reset), .loadA(loadA), .doSub(doSub),
        .a_in(a_in), .b_in(b_in), .x(x), .remainder(remainder),
        .quotient(quotient), .done(done), .div_zero(div_zero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge CLK);
        loadA = 1'b1; doSub = sub; a_in = a; b_in = b;
        @(negedge CLK);
        loadA = 1'b0;
    endtask

    // Load, push the expected result, hold doSub until done, then pop/compare.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int   cnt;
        exp_t got;
        sb.push_back(e);
        load(a, b, 1'b0);
        doSub = 1'b1;
        cnt = 0;
        while (!done && cnt < 400) begin
            @(negedge CLK);
            cnt++;
        end
        doSub = 1'b0;
        if (cnt >= 400) chk("timeout", cnt, -1);
        got = sb.pop_front();
        chk($sformatf("rem %0d mod %0d", a, b), remainder, got.rem);
        chk($sformatf("quot %0d / %0d", a, b), quotient, got.quot);
        chk($sformatf("dz %0d/%0d", a, b), div_zero, got.dz);
        chk($sformatf("x %0d/%0d", a, b), x, 1);
        chk($sformatf("edges %0d/%0d", a, b), cnt, int'(got.quot) + 1);
    endtask

    initial begin
        vecs[0] = '{8'd17,  8'd5,   8'd2,  8'd3,   1'b0};
        vecs[1] = '{8'd15,  8'd5,   8'd0,  8'd3,   1'b0};
        vecs[2] = '{8'd3,   8'd7,   8'd3,  8'd0,   1'b0};
        vecs[3] = '{8'd42,  8'd0,   8'd42, 8'd0,   1'b1};
        vecs[4] = '{8'd255, 8'd1,   8'd0,  8'd255, 1'b0};
        vecs[5] = '{8'd255, 8'd255, 8'd0,  8'd1,   1'b0};
        vecs[6] = '{8'd0,   8'd9,   8'd0,  8'd0,   1'b0};
        vecs[7] = '{8'd200, 8'd13,  8'd5,  8'd15,  1'b0};

        // Reset values
        #12;
        chk("rst rem", remainder, 0);
        chk("rst quot", quotient, 0);
        chk("rst done", done, 0);
        chk("rst dz", div_zero, 0);
        chk("rst x", x, 1);
        @(negedge CLK);
        reset = 1'b1;

        // Async reset between edges with regA=9
        load(8'd9, 8'd4, 1'b0);
        chk("pre-rst rem", remainder, 9);
        @(posedge CLK);
        #2;
        reset = 1'b0;
        #1;
        chk("async rem", remainder, 0);
        chk("async quot", quotient, 0);
        chk("async done", done, 0);
        chk("async dz", div_zero, 0);
        chk("async x", x, 1);
        @(negedge CLK);
        reset = 1'b1;

        // 17 mod 5 step by step: x low for 3 edges, done on the next
        load(8'd17, 8'd5, 1'b0);
        chk("17/5 x after load", x, 0);
        doSub = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("17/5 step%0d rem", i), remainder, 17 - 5 * i);
            chk($sformatf("17/5 step%0d x", i), x, (i == 3) ? 1 : 0);
            chk($sformatf("17/5 step%0d done", i), done, 0);
        end
        @(posedge CLK); #1;
        chk("17/5 done", done, 1);
        chk("17/5 rem", remainder, 2);
        chk("17/5 quot", quotient, 3);
        @(negedge CLK);
        doSub = 1'b0;
        repeat (3) @(negedge CLK);
        chk("17/5 hold rem", remainder, 2);
        chk("17/5 hold quot", quotient, 3);
        chk("17/5 hold done", done, 1);

        // Divide by zero held for 5 doSub edges
        load(8'd42, 8'd0, 1'b0);
        chk("dz x", x, 1);
        chk("dz flag", div_zero, 1);
        doSub = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("dz e%0d rem", i), remainder, 42);
            chk($sformatf("dz e%0d quot", i), quotient, 0);
            chk($sformatf("dz e%0d done", i), done, 1);
        end
        @(negedge CLK);
        doSub = 1'b0;

        // Restart: loadA wins over a simultaneous doSub
        load(8'd20, 8'd3, 1'b0);
        doSub = 1'b1;
        repeat (2) @(negedge CLK);
        doSub = 1'b0;
        chk("restart mid rem", remainder, 14);
        chk("restart mid quot", quotient, 2);
        load(8'd10, 8'd4, 1'b1);
        chk("restart rem", remainder, 10);
        chk("restart quot", quotient, 0);
        chk("restart done", done, 0);
        doSub = 1'b1;
        begin : restart_wait
            int cnt;
            cnt = 0;
            while (!done && cnt < 50) begin
                @(negedge CLK);
                cnt++;
            end
            if (cnt >= 50) chk("restart timeout", cnt, -1);
        end
        doSub = 1'b0;
        chk("restart final rem", remainder, 2);
        chk("restart final quot", quotient, 2);

        // Table-driven operations through the scoreboard
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, '{vecs[i].rem, vecs[i].quot, vecs[i].dz});

        // Random operations, expected values from an arithmetic model
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            exp_t e;
            ra = W'($urandom_range(255, 0));
            rb = W'($urandom_range(40, 0));
            if (rb == 0) e = '{ra, '0, 1'b1};
            else         e = '{ra % rb, ra / rb, 1'b0};
            run_op(ra, rb, e);
        end

        chk("sb empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
